// File: rtl/itch_pkg.sv
// Shared ITCH definitions: word geometry, buffered-word record, buffer occupancy
// states and the message-length lookup also used by the downstream decoders.
package itch_pkg;

  localparam int ITCH_WORD_BYTES = 8;
  localparam int ITCH_NB_W       = $clog2(ITCH_WORD_BYTES + 1);

  typedef struct packed {
    logic [8*ITCH_WORD_BYTES-1:0] data;
    logic [ITCH_WORD_BYTES-1:0]   keep;
    logic                         last;
    logic [ITCH_NB_W-1:0]         nbytes;
  } itch_word_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_e;

  // Compact in-house layout: type byte followed by the fixed fields.
  function automatic logic [7:0] itch_length(input logic [7:0] msg_type);
    case (msg_type)
      8'h41:   return 8'd26; // A add
      8'h44:   return 8'd9;  // D delete
      8'h58:   return 8'd13; // X cancel
      8'h55:   return 8'd25; // U replace
      8'h45:   return 8'd13; // E execute
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_word_serializer_if.sv
// Word-stream handshake between the transport unpacker and the serializer.
interface itch_word_serializer_if
  import itch_pkg::*;
#(
  parameter int WORD_BYTES = ITCH_WORD_BYTES
);
  logic [8*WORD_BYTES-1:0] s_data;
  logic [WORD_BYTES-1:0]   s_keep;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;

  modport master (output s_data, s_keep, s_last, s_valid, input s_ready);
  modport slave  (input s_data, s_keep, s_last, s_valid, output s_ready);
endinterface

// File: rtl/itch_keep_check.sv
// Combinational lane-mask check: legal masks are nonzero and contiguous from lane 0.
module itch_keep_check #(
  parameter int WB = 8
) (
  input  logic [WB-1:0]            keep,
  output logic                     legal,
  output logic [$clog2(WB+1)-1:0]  nbytes
);
  localparam int NBW = $clog2(WB + 1);

  logic [WB-1:0] keep_p1;

  always_comb begin
    keep_p1 = keep + 1'b1;
    // Low-aligned run of ones turns into a single carry, so keep & (keep+1) is zero.
    legal   = (keep != '0) && ((keep & keep_p1) == '0);
    nbytes  = '0;
    for (int unsigned i = 0; i < WB; i++) begin
      nbytes = nbytes + NBW'(keep[i]);
    end
  end
endmodule

// File: rtl/itch_word_serializer.sv
// Two-slot word buffer feeding the ITCH decoders one byte per cycle, with
// frame accounting, illegal-mask detection and mid-frame underrun flags.
module itch_word_serializer
  import itch_pkg::*;
#(
  parameter int WORD_BYTES  = ITCH_WORD_BYTES,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  itch_word_serializer_if.slave  s,
  output logic [7:0]             byte_out,
  output logic                   valid_out,
  output logic                   frame_end,
  output logic [FRAME_CNT_W-1:0] frame_bytes,
  output logic                   keep_error,
  output logic                   underrun
);
  localparam int LW = $clog2(WORD_BYTES);

  buf_state_e           st, st_n;
  itch_word_t           cur, cur_n, nxt, nxt_n, in_w;
  logic [LW-1:0]        lane, lane_n;
  logic                 rdy_q;
  logic [FRAME_CNT_W-1:0] cnt, cnt_n, cnt_after, fb_n;
  logic                 in_frame, inf_n;
  logic [7:0]           byte_n;
  logic                 valid_n, fe_n, ke_n, ur_n;
  logic                 acc, take, emit_last, close, lane_is_last;
  logic                 kc_legal;
  logic [ITCH_NB_W-1:0] kc_nbytes;

  itch_keep_check #(.WB(WORD_BYTES)) u_keep_check (
    .keep   (s.s_keep),
    .legal  (kc_legal),
    .nbytes (kc_nbytes)
  );

  assign s.s_ready = rdy_q;

  always_comb begin
    in_w.data   = s.s_data;
    in_w.keep   = s.s_keep;
    in_w.last   = s.s_last;
    in_w.nbytes = kc_nbytes;
  end

  always_comb begin
    st_n      = st;
    cur_n     = cur;
    nxt_n     = nxt;
    lane_n    = lane;
    byte_n    = '0;
    valid_n   = 1'b0;
    emit_last = 1'b0;
    fe_n      = 1'b0;
    fb_n      = '0;
    cnt_n     = cnt;
    inf_n     = in_frame;
    acc       = s.s_valid & rdy_q;
    take      = acc & kc_legal;
    ke_n      = acc & ~kc_legal;
    lane_is_last = (ITCH_NB_W'(lane) == cur.nbytes - 1'b1);

    case (st)
      BUF_EMPTY: begin
        // Bypass: lane 0 of a word landing in an empty buffer goes straight out.
        if (take) begin
          valid_n = 1'b1;
          byte_n  = in_w.data[7:0];
          if (in_w.nbytes == ITCH_NB_W'(1)) begin
            emit_last = in_w.last;
          end else begin
            cur_n  = in_w;
            lane_n = LW'(1);
            st_n   = BUF_ONE;
          end
        end
      end
      default: begin
        valid_n = cur.keep[lane];
        byte_n  = cur.data[{lane, 3'b000} +: 8];
        if (lane_is_last) begin
          emit_last = cur.last;
          lane_n    = '0;
          if (st == BUF_TWO) begin
            cur_n = nxt;
            st_n  = BUF_ONE;
          end else if (take) begin
            cur_n = in_w;
          end else begin
            st_n = BUF_EMPTY;
          end
        end else begin
          lane_n = lane + 1'b1;
          if (take) begin
            nxt_n = in_w;
            st_n  = BUF_TWO;
          end
        end
      end
    endcase

    cnt_after = valid_n ? ((cnt == '1) ? cnt : cnt + 1'b1) : cnt;
    close     = emit_last | (ke_n & s.s_last);
    if (close) begin
      fe_n  = 1'b1;
      fb_n  = cnt_after;
      cnt_n = '0;
      inf_n = 1'b0;
    end else begin
      cnt_n = cnt_after;
      if (valid_n) inf_n = 1'b1;
    end
    ur_n = inf_n & ~valid_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= BUF_EMPTY;
      cur         <= '0;
      nxt         <= '0;
      lane        <= '0;
      rdy_q       <= 1'b0;
      cnt         <= '0;
      in_frame    <= 1'b0;
      byte_out    <= '0;
      valid_out   <= 1'b0;
      frame_end   <= 1'b0;
      frame_bytes <= '0;
      keep_error  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      st          <= st_n;
      cur         <= cur_n;
      nxt         <= nxt_n;
      lane        <= lane_n;
      rdy_q       <= (st_n != BUF_TWO);
      cnt         <= cnt_n;
      in_frame    <= inf_n;
      byte_out    <= byte_n;
      valid_out   <= valid_n;
      frame_end   <= fe_n;
      frame_bytes <= fb_n;
      keep_error  <= ke_n;
      underrun    <= ur_n;
    end
  end
endmodule
